// File: rtl/conv1d_job_sequencer_pkg.sv
// conv1d_seq_pkg: shared types and constants for the conv1d job sequencer.
// Holds the sequencer state encoding, CFU command codes and the job
// legality check used when a descriptor is accepted.
package conv1d_seq_pkg;

    localparam int KERNEL_LENGTH      = 8;
    localparam int MAX_INPUT_CHANNELS = 128;
    localparam int INT32_SIZE         = 32;
    localparam int BYTE_SIZE          = 8;
    localparam int SX_W               = $clog2(KERNEL_LENGTH);

    typedef enum logic [3:0] {
        IDLE,
        SET_PARAM,
        LOAD_W,
        PRIME,
        START,
        POLL,
        READ,
        WAIT_RES,
        SHIFT
    } state_t;

    typedef enum logic [6:0] {
        CMD_WR_INPUT  = 7'd1,
        CMD_WR_WEIGHT = 7'd2,
        CMD_OFFSET    = 7'd3,
        CMD_DEPTH     = 7'd5,
        CMD_START     = 7'd6,
        CMD_GET_ACC   = 7'd7,
        CMD_START_X   = 7'd8,
        CMD_DONE      = 7'd9,
        CMD_NOP       = 7'd127
    } cfu_cmd_t;

    // A job needs at least one channel, no more than the buffers hold,
    // and at least one output position.
    function automatic logic job_legal(input logic [INT32_SIZE-1:0] depth,
                                       input logic [15:0]           num_outputs);
        return (depth != '0) &&
               (depth <= INT32_SIZE'(MAX_INPUT_CHANNELS)) &&
               (num_outputs != '0);
    endfunction

endpackage

// File: rtl/conv1d_job_sequencer_if.sv
// conv1d_job_sequencer_if: the conv1d CFU command port.
// The sequencer is the master (issues en/cmd/inp0/inp1), the CFU is the
// slave and answers on ret one cycle after each command.
interface conv1d_job_sequencer_if;
    import conv1d_seq_pkg::*;

    logic                  en;
    logic [6:0]            cmd;
    logic [INT32_SIZE-1:0] inp0;
    logic [INT32_SIZE-1:0] inp1;
    logic [INT32_SIZE-1:0] ret;

    modport master (output en, cmd, inp0, inp1, input ret);
    modport slave  (input en, cmd, inp0, inp1, output ret);

endinterface

// File: rtl/conv1d_job_sequencer.sv
// conv1d_job_sequencer: hardware master for the conv1d CFU.
// Accepts a job descriptor, loads parameters, weights and the first
// KERNEL_LENGTH input columns, then per output position starts the MAC,
// polls for completion, reads the accumulator onto the result stream and
// refills the oldest ring slot with the next column.
// Optional feature: define CONV1D_SEQ_PERF_EN to add perf_poll_cycles,
// a saturating count of cycles spent polling, cleared on job accept.
module conv1d_job_sequencer
    import conv1d_seq_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cfg_valid,
    output logic                  cfg_ready,
    input  logic [INT32_SIZE-1:0] cfg_input_depth,
    input  logic [INT32_SIZE-1:0] cfg_input_offset,
    input  logic [15:0]           cfg_num_outputs,
    input  logic                  wt_valid,
    output logic                  wt_ready,
    input  logic [BYTE_SIZE-1:0]  wt_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [BYTE_SIZE-1:0]  in_data,
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic [INT32_SIZE-1:0] res_data,
    output logic                  busy,
    output logic                  err,
    conv1d_job_sequencer_if.master cfu
`ifdef CONV1D_SEQ_PERF_EN
    ,
    output logic [31:0]           perf_poll_cycles
`endif
);

    state_t                state;
    logic [1:0]            phase;
    logic [INT32_SIZE-1:0] depth;
    logic [INT32_SIZE-1:0] offset;
    logic [INT32_SIZE-1:0] n_total;
    logic [INT32_SIZE-1:0] idx;
    logic [INT32_SIZE-1:0] ch;
    logic [15:0]           num_outputs;
    logic [15:0]           outputs_done;
    logic [SX_W-1:0]       start_x;

    logic cfg_fire;
    assign cfg_fire = (state == IDLE) && cfg_valid && cfg_ready;

    // Job FSM: all stream handshakes and CFU command outputs are registered here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            phase        <= '0;
            depth        <= '0;
            offset       <= '0;
            n_total      <= '0;
            idx          <= '0;
            ch           <= '0;
            num_outputs  <= '0;
            outputs_done <= '0;
            start_x      <= '0;
            cfg_ready    <= 1'b0;
            wt_ready     <= 1'b0;
            in_ready     <= 1'b0;
            res_valid    <= 1'b0;
            res_data     <= '0;
            busy         <= 1'b0;
            err          <= 1'b0;
            cfu.en       <= 1'b0;
            cfu.cmd      <= CMD_NOP;
            cfu.inp0     <= '0;
            cfu.inp1     <= '0;
        end else begin
            // NOTE: every register here uses <= so all branches see start-of-cycle
            // values; the NOP default below is overridden by the one command
            // (if any) issued this cycle, giving exactly one command per cycle.
            cfu.en   <= 1'b1;
            cfu.cmd  <= CMD_NOP;
            cfu.inp0 <= '0;
            cfu.inp1 <= '0;
            err      <= 1'b0;

            case (state)
                IDLE: begin
                    cfg_ready <= 1'b1;
                    if (cfg_fire) begin
                        if (job_legal(cfg_input_depth, cfg_num_outputs)) begin
                            depth        <= cfg_input_depth;
                            offset       <= cfg_input_offset;
                            num_outputs  <= cfg_num_outputs;
                            n_total      <= cfg_input_depth * INT32_SIZE'(KERNEL_LENGTH);
                            outputs_done <= '0;
                            phase        <= '0;
                            cfg_ready    <= 1'b0;
                            busy         <= 1'b1;
                            state        <= SET_PARAM;
                        end else begin
                            err <= 1'b1;
                        end
                    end
                end

                SET_PARAM: begin
                    if (phase == 2'd0) begin
                        cfu.cmd  <= CMD_OFFSET;
                        cfu.inp1 <= offset;
                        phase    <= 2'd1;
                    end else begin
                        cfu.cmd  <= CMD_DEPTH;
                        cfu.inp1 <= depth;
                        idx      <= '0;
                        wt_ready <= 1'b1;
                        state    <= LOAD_W;
                    end
                end

                LOAD_W: begin
                    if (wt_valid && wt_ready) begin
                        cfu.cmd  <= CMD_WR_WEIGHT;
                        cfu.inp0 <= idx;
                        cfu.inp1 <= {{(INT32_SIZE-BYTE_SIZE){1'b0}}, wt_data};
                        idx      <= idx + 1'b1;
                        if (idx == n_total - 1'b1) begin
                            wt_ready <= 1'b0;
                            in_ready <= 1'b1;
                            idx      <= '0;
                            state    <= PRIME;
                        end
                    end
                end

                PRIME: begin
                    if (in_valid && in_ready) begin
                        cfu.cmd  <= CMD_WR_INPUT;
                        cfu.inp0 <= idx;
                        cfu.inp1 <= {{(INT32_SIZE-BYTE_SIZE){1'b0}}, in_data};
                        idx      <= idx + 1'b1;
                        if (idx == n_total - 1'b1) begin
                            in_ready <= 1'b0;
                            start_x  <= '0;
                            phase    <= '0;
                            state    <= START;
                        end
                    end
                end

                START: begin
                    if (phase == 2'd0) begin
                        cfu.cmd  <= CMD_START_X;
                        cfu.inp1 <= INT32_SIZE'(start_x);
                        phase    <= 2'd1;
                    end else begin
                        cfu.cmd <= CMD_START;
                        phase   <= '0;
                        state   <= POLL;
                    end
                end

                // Phase 0 issues DONE, phase 1 idles while ret settles, phase 2 samples.
                POLL: begin
                    if (phase == 2'd0) begin
                        cfu.cmd <= CMD_DONE;
                        phase   <= 2'd1;
                    end else if (phase == 2'd1) begin
                        phase <= 2'd2;
                    end else if (cfu.ret[0]) begin
                        phase <= '0;
                        state <= READ;
                    end else begin
                        cfu.cmd <= CMD_DONE;
                        phase   <= 2'd1;
                    end
                end

                READ: begin
                    if (phase == 2'd0) begin
                        cfu.cmd <= CMD_GET_ACC;
                        phase   <= 2'd1;
                    end else if (phase == 2'd1) begin
                        phase <= 2'd2;
                    end else begin
                        res_data     <= cfu.ret;
                        res_valid    <= 1'b1;
                        outputs_done <= outputs_done + 1'b1;
                        phase        <= '0;
                        state        <= WAIT_RES;
                    end
                end

                WAIT_RES: begin
                    if (res_valid && res_ready) begin
                        res_valid <= 1'b0;
                        if (outputs_done == num_outputs) begin
                            busy      <= 1'b0;
                            cfg_ready <= 1'b1;
                            state     <= IDLE;
                        end else begin
                            idx      <= INT32_SIZE'(start_x) * depth;
                            ch       <= '0;
                            in_ready <= 1'b1;
                            state    <= SHIFT;
                        end
                    end
                end

                // Overwrite the oldest ring slot, then advance the window start.
                SHIFT: begin
                    if (in_valid && in_ready) begin
                        cfu.cmd  <= CMD_WR_INPUT;
                        cfu.inp0 <= idx;
                        cfu.inp1 <= {{(INT32_SIZE-BYTE_SIZE){1'b0}}, in_data};
                        idx      <= idx + 1'b1;
                        ch       <= ch + 1'b1;
                        if (ch == depth - 1'b1) begin
                            in_ready <= 1'b0;
                            start_x  <= (start_x == SX_W'(KERNEL_LENGTH - 1)) ? '0 : start_x + 1'b1;
                            phase    <= '0;
                            state    <= START;
                        end
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

`ifdef CONV1D_SEQ_PERF_EN
    // Poll-cycle counter: cleared on any descriptor accept, saturating.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_poll_cycles <= '0;
        end else if (cfg_fire) begin
            perf_poll_cycles <= '0;
        end else if (state == POLL && perf_poll_cycles != 32'hFFFF_FFFF) begin
            perf_poll_cycles <= perf_poll_cycles + 1'b1;
        end
    end
`endif

endmodule
